audio_dac_tx: RTL and testbench
===============================

AUDIO_DAC_TX -- requirements
Module: audio_dac_tx

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, meaning sample buffer entries (power of two, 2..16).
REQ-002 SHALL have parameter SAMPLE_W, default 16, meaning audio sample width in bits.
REQ-003 SHALL have port i_clk, input, 1 bit: system clock, 50 MHz nominal.
REQ-004 SHALL have port i_rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port i_valid, input, 1 bit: one-cycle strobe marking i_data as a new sample from the effect chain.
REQ-006 SHALL have port i_data, input, SAMPLE_W bits: signed two's-complement sample.
REQ-007 SHALL have port i_enable, input, 1 bit: 1 = play; 0 = mute and flush.
REQ-008 SHALL have port i_clr_flags, input, 1 bit: one-cycle strobe that clears the sticky flags.
REQ-009 SHALL have port i_aud_bclk, input, 1 bit: codec bit clock, asynchronous to i_clk.
REQ-010 SHALL have port i_aud_daclrck, input, 1 bit: codec frame clock (0 = left, 1 = right), asynchronous to i_clk.
REQ-011 SHALL have port o_aud_dacdat, output, 1 bit: I2S serial data to the codec DAC.
REQ-012 SHALL have port o_level, output, $clog2(FIFO_DEPTH)+1 bits: current FIFO occupancy.
REQ-013 SHALL have port o_overflow, output, 1 bit: sticky flag, sample dropped.
REQ-014 SHALL have port o_underflow, output, 1 bit: sticky flag, frame started with the FIFO empty.

Function
REQ-015 SHALL synchronise i_aud_bclk and i_aud_daclrck through 2 flops each, then detect edges with a third flop; i_clk SHALL be at least 8x BCLK.
REQ-016 SHALL push i_data into the FIFO on every i_valid while i_enable=1; there is no backpressure.
REQ-017 SHALL drop the sample and set o_overflow when i_valid arrives while the FIFO is full and no pop occurs in the same cycle.
REQ-018 SHALL perform both the push and the pop when they coincide on a full FIFO, with level unchanged and no overflow.
REQ-019 SHALL, on a synchronised LRCK falling edge (left frame start), pop the FIFO head into the 16-bit hold register when the FIFO is non-empty.
REQ-020 SHALL, when the FIFO is empty at a left frame start, retain the hold register and set o_underflow.
REQ-021 SHALL send the hold register on both the left and right channels (mono duplication).
REQ-022 SHALL implement a state machine with states IDLE and SHIFT.
REQ-023 SHALL, on any LRCK edge in any state: load the shift register from the hold register (after any pop in the same cycle), load bit counter = SAMPLE_W, and enter SHIFT.
REQ-024 SHALL, in SHIFT on each synchronised BCLK falling edge: drive o_aud_dacdat = shift[MSB], shift left by 1, decrement the counter; after the SAMPLE_W-th bit, enter IDLE.
REQ-025 SHALL ignore a BCLK falling edge detected in the same cycle as an LRCK edge, so the MSB is valid at the second BCLK rising edge after the LRCK transition (I2S mode).
REQ-026 SHALL drive o_aud_dacdat = 0 in IDLE, i.e. bits beyond SAMPLE_W.
REQ-027 SHALL, while i_enable=0: flush the FIFO, clear the hold register to 0, force IDLE, and drive o_aud_dacdat=0; flags SHALL hold their values.
REQ-028 SHALL, when i_enable rises mid-frame, output nothing until the next LRCK edge.
REQ-029 SHALL let i_clr_flags take priority over a same-cycle flag set, so both flags read 0 on the next cycle.
REQ-030 SHALL update o_level registered, one cycle after the push/pop.

Reset
REQ-031 SHALL, while i_rst_n=0, hold FIFO empty, o_level=0, hold=0, shift=0, counter=0, state=IDLE, o_aud_dacdat=0, o_overflow=0, o_underflow=0, and synchroniser flops=0.
REQ-032 SHALL, after reset release, treat the first LRCK edge as a normal frame start; a reset mid-frame truncates that frame.

Structure
REQ-033 SHALL define SAMPLE_W, the default FIFO_DEPTH, and the state enum typedef (IDLE, SHIFT) in shared package audio_pkg.
REQ-034 SHALL implement the FIFO as sub-module audio_sample_fifo: push, pop, flush, full, empty, level, and a head output that is combinationally visible.

Verification
REQ-035 SHALL cover: push 0x7FFF, then LRCK fall followed by 16 BCLK cycles -> left-channel bits 0111_1111_1111_1111, with the MSB sampled at the 2nd BCLK rise, then the identical word on the right channel.
REQ-036 SHALL cover: 5 i_valid strobes (0x0001..0x0005) with no LRCK activity and FIFO_DEPTH=4 -> o_level=4, o_overflow=1, and subsequent frames play 1,2,3,4.
REQ-037 SHALL cover: FIFO empty at LRCK fall with previous sample 0x8000 -> 0x8000 replayed and o_underflow=1; i_clr_flags -> flag 0 on the next cycle.
REQ-038 SHALL cover: FIFO full with i_valid coinciding with the pop cycle -> o_overflow stays 0 and o_level stays 4.
REQ-039 SHALL cover: i_enable dropped mid-shift -> o_aud_dacdat=0 next cycle and o_level=0; re-enable plus push 0x1234 -> clean frame starting at the next LRCK fall.
REQ-040 SHALL cover: i_rst_n asserted during bit 7 of a frame -> all outputs 0 immediately (asynchronous), and normal operation from the next LRCK edge after release.

Source files
------------

// File: rtl/audio_pkg.sv
// Shared constants and the serialiser state type for the audio DAC transmit path.
package audio_pkg;

   localparam int SAMPLE_W           = 16;
   localparam int FIFO_DEPTH_DEFAULT = 4;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } tx_state_t;

endpackage

// File: rtl/audio_sample_fifo.sv
// Small sample FIFO with a combinational head output so the consumer can take the
// head and pop it in the same cycle.
module audio_sample_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 16
) (
   input  logic                     i_clk,
   input  logic                     i_rst_n,
   input  logic                     push,
   input  logic                     pop,
   input  logic                     flush,
   input  logic [W-1:0]             wr_data,
   output logic [W-1:0]             head,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr_reg;
   logic [AW-1:0] rd_ptr_reg;
   logic [AW:0]   count_reg;
   logic          push_ok;
   logic          pop_ok;

   // A push into a full FIFO is only legal when the head leaves in the same cycle.
   assign push_ok = push & ~flush & (~full | pop_ok);
   assign pop_ok  = pop & ~flush & ~empty;

   assign full  = (count_reg == (AW+1)'(DEPTH));
   assign empty = (count_reg == '0);
   assign head  = mem[rd_ptr_reg];
   assign level = count_reg;

   always_ff @(posedge i_clk) begin
      if (push_ok) begin
         mem[wr_ptr_reg] <= wr_data;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else if (flush) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         end
         if (pop_ok) begin
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
         end
         case ({push_ok, pop_ok})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: count_reg <= count_reg;
         endcase
      end
   end

endmodule

// File: rtl/audio_dac_tx.sv
// I2S transmitter: buffers mono samples and serialises each one onto both channels,
// clocked by codec BCLK/LRCK sampled in the system clock domain.
module audio_dac_tx #(
   parameter int FIFO_DEPTH = audio_pkg::FIFO_DEPTH_DEFAULT,
   parameter int SAMPLE_W   = audio_pkg::SAMPLE_W
) (
   input  logic                          i_clk,
   input  logic                          i_rst_n,
   input  logic                          i_valid,
   input  logic [SAMPLE_W-1:0]           i_data,
   input  logic                          i_enable,
   input  logic                          i_clr_flags,
   input  logic                          i_aud_bclk,
   input  logic                          i_aud_daclrck,
   output logic                          o_aud_dacdat,
   output logic [$clog2(FIFO_DEPTH):0]   o_level,
   output logic                          o_overflow,
   output logic                          o_underflow
);

   import audio_pkg::*;

   localparam int CNT_W = $clog2(SAMPLE_W + 1);

   // Bits [1:0] are the two-flop synchroniser, bit [2] is the edge-detect history.
   logic [2:0]          bclk_sync_reg;
   logic [2:0]          lrck_sync_reg;
   logic                bclk_fall;
   logic                lrck_edge;
   logic                lrck_fall;

   logic                fifo_push;
   logic                fifo_pop;
   logic                fifo_full;
   logic                fifo_empty;
   logic [SAMPLE_W-1:0] fifo_head;
   logic                ovf_set;
   logic                unf_set;

   logic [SAMPLE_W-1:0] hold_reg;
   logic [SAMPLE_W-1:0] hold_next;
   tx_state_t           state_reg;
   tx_state_t           state_next;
   logic [SAMPLE_W-1:0] shift_reg;
   logic [SAMPLE_W-1:0] shift_next;
   logic [CNT_W-1:0]    cnt_reg;
   logic [CNT_W-1:0]    cnt_next;
   logic                dacdat_reg;
   logic                dacdat_next;
   logic                overflow_reg;
   logic                underflow_reg;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         bclk_sync_reg <= '0;
         lrck_sync_reg <= '0;
      end else begin
         bclk_sync_reg <= {bclk_sync_reg[1:0], i_aud_bclk};
         lrck_sync_reg <= {lrck_sync_reg[1:0], i_aud_daclrck};
      end
   end

   assign bclk_fall = bclk_sync_reg[2] & ~bclk_sync_reg[1];
   assign lrck_edge = lrck_sync_reg[2] ^ lrck_sync_reg[1];
   assign lrck_fall = lrck_sync_reg[2] & ~lrck_sync_reg[1];

   assign fifo_pop  = i_enable & lrck_fall & ~fifo_empty;
   assign fifo_push = i_enable & i_valid & (~fifo_full | fifo_pop);
   assign ovf_set   = i_enable & i_valid & fifo_full & ~fifo_pop;
   assign unf_set   = i_enable & lrck_fall & fifo_empty;

   audio_sample_fifo #(
      .DEPTH (FIFO_DEPTH),
      .W     (SAMPLE_W)
   ) u_fifo (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .push    (fifo_push),
      .pop     (fifo_pop),
      .flush   (~i_enable),
      .wr_data (i_data),
      .head    (fifo_head),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .level   (o_level)
   );

   // On an empty left frame start the previous sample is replayed.
   always_comb begin
      hold_next = hold_reg;
      if (!i_enable) begin
         hold_next = '0;
      end else if (fifo_pop) begin
         hold_next = fifo_head;
      end
   end

   // A BCLK fall coinciding with an LRCK edge is swallowed to give the I2S one-bit delay.
   always_comb begin
      state_next  = state_reg;
      shift_next  = shift_reg;
      cnt_next    = cnt_reg;
      dacdat_next = dacdat_reg;
      if (!i_enable) begin
         state_next  = IDLE;
         shift_next  = '0;
         cnt_next    = '0;
         dacdat_next = 1'b0;
      end else if (lrck_edge) begin
         state_next = SHIFT;
         shift_next = hold_next;
         cnt_next   = CNT_W'(SAMPLE_W);
      end else if (bclk_fall) begin
         if (state_reg == SHIFT) begin
            dacdat_next = shift_reg[SAMPLE_W-1];
            shift_next  = {shift_reg[SAMPLE_W-2:0], 1'b0};
            cnt_next    = cnt_reg - 1'b1;
            if (cnt_reg == CNT_W'(1)) begin
               state_next = IDLE;
            end
         end else begin
            dacdat_next = 1'b0;
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         hold_reg   <= '0;
         state_reg  <= IDLE;
         shift_reg  <= '0;
         cnt_reg    <= '0;
         dacdat_reg <= 1'b0;
      end else begin
         hold_reg   <= hold_next;
         state_reg  <= state_next;
         shift_reg  <= shift_next;
         cnt_reg    <= cnt_next;
         dacdat_reg <= dacdat_next;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         overflow_reg  <= 1'b0;
         underflow_reg <= 1'b0;
      end else if (i_clr_flags) begin
         overflow_reg  <= 1'b0;
         underflow_reg <= 1'b0;
      end else begin
         overflow_reg  <= overflow_reg | ovf_set;
         underflow_reg <= underflow_reg | unf_set;
      end
   end

   assign o_aud_dacdat = dacdat_reg;
   assign o_overflow   = overflow_reg;
   assign o_underflow  = underflow_reg;

endmodule

// File: tb/tb_audio_dac_tx.sv
// Directed bench: drives a codec-style BCLK/LRCK schedule and checks the serial stream,
// FIFO level and flags against a queue-based model of the transmitter.
module tb_audio_dac_tx;

   localparam int DEPTH = 4;

   logic        i_clk = 1'b0;
   logic        i_rst_n = 1'b0;
   logic        i_valid = 1'b0;
   logic [15:0] i_data = '0;
   logic        i_enable = 1'b1;
   logic        i_clr_flags = 1'b0;
   logic        i_aud_bclk = 1'b0;
   logic        i_aud_daclrck = 1'b0;
   logic        o_aud_dacdat;
   logic [2:0]  o_level;
   logic        o_overflow;
   logic        o_underflow;

   audio_dac_tx #(
      .FIFO_DEPTH (DEPTH),
      .SAMPLE_W   (16)
   ) dut (
      .i_clk         (i_clk),
      .i_rst_n       (i_rst_n),
      .i_valid       (i_valid),
      .i_data        (i_data),
      .i_enable      (i_enable),
      .i_clr_flags   (i_clr_flags),
      .i_aud_bclk    (i_aud_bclk),
      .i_aud_daclrck (i_aud_daclrck),
      .o_aud_dacdat  (o_aud_dacdat),
      .o_level       (o_level),
      .o_overflow    (o_overflow),
      .o_underflow   (o_underflow)
   );

   always #10 i_clk = ~i_clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Codec schedule: 10 clocks per BCLK, 24 BCLKs per channel; LRCK flips with a BCLK fall.
   int ph   = 9;
   int slot = 8;
   int ch   = 0;

   // Model: sample queue, hold value, word being sent this channel, sticky flags.
   logic [15:0] mq [$];
   logic [15:0] m_hold = '0;
   logic [15:0] m_word = '0;
   bit          m_active = 1'b0;
   bit          m_ovf = 1'b0;
   bit          m_unf = 1'b0;
   logic [15:0] cap = '0;
   logic [15:0] last_w [2];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step(input bit v, input logic [15:0] d, input bit clr);
      logic exp_bit;
      @(negedge i_clk);
      ph++;
      if (ph == 10) begin
         ph = 0;
         slot++;
         if (slot == 24) begin
            slot = 0;
            ch = 1 - ch;
         end
      end
      i_aud_bclk    = (ph >= 5);
      i_aud_daclrck = (ch == 1);
      i_valid       = v;
      i_data        = d;
      i_clr_flags   = clr;
      if (!i_rst_n) begin
         mq.delete();
         m_hold = '0;
         m_active = 1'b0;
         m_ovf = 1'b0;
         m_unf = 1'b0;
      end else begin
         if (!i_enable) begin
            mq.delete();
            m_hold = '0;
            m_active = 1'b0;
         end else begin
            if (ph == 0 && slot == 0) begin
               if (ch == 0) begin
                  if (mq.size() > 0) m_hold = mq.pop_front();
                  else m_unf = 1'b1;
               end
               m_word = m_hold;
               m_active = 1'b1;
            end
            if (v) begin
               if (mq.size() == DEPTH) m_ovf = 1'b1;
               else mq.push_back(d);
            end
         end
         if (clr) begin
            m_ovf = 1'b0;
            m_unf = 1'b0;
         end
      end
      // Codec samples DACDAT on the BCLK rise: slot 0 is the I2S delay bit, 1..16 carry MSB..LSB.
      if (ph == 5) begin
         exp_bit = (m_active && slot >= 1 && slot <= 16) ? m_word[16-slot] : 1'b0;
         chk("dacdat_bit", {31'd0, o_aud_dacdat}, {31'd0, exp_bit});
         chk("level", {29'd0, o_level}, mq.size());
         chk("overflow", {31'd0, o_overflow}, {31'd0, m_ovf});
         chk("underflow", {31'd0, o_underflow}, {31'd0, m_unf});
         if (slot >= 1 && slot <= 16) cap = {cap[14:0], o_aud_dacdat};
         if (slot == 16) last_w[ch] = cap;
      end
   endtask

   task automatic step_until(input int c, input int s, input int p);
      int guard = 0;
      do begin
         step(1'b0, 16'h0, 1'b0);
         guard++;
      end while (!(ch == c && slot == s && ph == p) && guard < 3000);
      if (guard >= 3000) begin
         n_checks++;
         n_fail++;
         $display("FAIL step_until timeout: got no match expected ch%0d slot%0d ph%0d", c, s, p);
      end
   endtask

   task automatic push_at(input int c, input int s, input logic [15:0] v);
      step_until(c, s, 6);
      step(1'b1, v, 1'b0);
   endtask

   initial begin
      repeat (3) @(negedge i_clk);
      chk("rst_dacdat", {31'd0, o_aud_dacdat}, 0);
      chk("rst_level", {29'd0, o_level}, 0);
      chk("rst_overflow", {31'd0, o_overflow}, 0);
      chk("rst_underflow", {31'd0, o_underflow}, 0);
      i_rst_n = 1'b1;

      // Single sample 0x7FFF played on left then right.
      push_at(0, 10, 16'h7FFF);
      step_until(1, 0, 1);
      step_until(0, 17, 0);
      chk("left_7fff", {16'd0, last_w[0]}, 32'h7FFF);
      step_until(1, 17, 0);
      chk("right_7fff", {16'd0, last_w[1]}, 32'h7FFF);

      // Five pushes into a depth-4 FIFO with no frame start in between.
      for (int k = 1; k <= 5; k++) push_at(1, 17 + k, 16'(k));
      step_until(1, 23, 6);
      chk("ovf_level", {29'd0, o_level}, 4);
      chk("ovf_flag", {31'd0, o_overflow}, 1);
      for (int k = 1; k <= 4; k++) begin
         step_until(0, 17, 0);
         chk("play_left", {16'd0, last_w[0]}, k);
         if (k == 1) begin
            step(1'b0, 16'h0, 1'b1);
            step(1'b0, 16'h0, 1'b0);
            chk("clr_ovf", {31'd0, o_overflow}, 0);
            chk("clr_unf", {31'd0, o_underflow}, 0);
         end
         if (k == 4) push_at(0, 20, 16'h8000);
         step_until(1, 17, 0);
         chk("play_right", {16'd0, last_w[1]}, k);
      end
      step_until(0, 17, 0);
      chk("left_8000", {16'd0, last_w[0]}, 32'h8000);
      chk("no_unf_yet", {31'd0, o_underflow}, 0);
      step_until(1, 17, 0);

      // Empty at left frame start: previous sample replays and underflow sets.
      step_until(0, 17, 0);
      chk("replay_8000", {16'd0, last_w[0]}, 32'h8000);
      chk("unf_flag", {31'd0, o_underflow}, 1);
      step(1'b0, 16'h0, 1'b1);
      step(1'b0, 16'h0, 1'b0);
      chk("unf_clr", {31'd0, o_underflow}, 0);
      step_until(1, 17, 0);
      chk("replay_8000_r", {16'd0, last_w[1]}, 32'h8000);

      // Full FIFO with a push landing in the pop cycle.
      push_at(1, 18, 16'hA00A);
      push_at(1, 19, 16'hB00B);
      push_at(1, 20, 16'hC00C);
      push_at(1, 21, 16'hD00D);
      step_until(0, 0, 0);
      step(1'b0, 16'h0, 1'b0);
      step(1'b1, 16'hE00E, 1'b0);
      step_until(0, 3, 6);
      chk("coinc_ovf", {31'd0, o_overflow}, 0);
      chk("coinc_level", {29'd0, o_level}, 4);
      step_until(0, 17, 0);
      chk("left_a00a", {16'd0, last_w[0]}, 32'hA00A);

      // Disable mid-shift, then re-enable mid-frame.
      step_until(0, 4, 2);
      chk("pre_dis_dat", {31'd0, o_aud_dacdat}, 1);
      i_enable = 1'b0;
      step(1'b0, 16'h0, 1'b0);
      chk("dis_dacdat", {31'd0, o_aud_dacdat}, 0);
      chk("dis_level", {29'd0, o_level}, 0);
      step_until(0, 10, 2);
      i_enable = 1'b1;
      push_at(0, 12, 16'h1234);
      step_until(1, 17, 0);
      chk("reen_silent", {16'd0, last_w[1]}, 0);
      step_until(0, 17, 0);
      chk("left_1234", {16'd0, last_w[0]}, 32'h1234);
      step_until(1, 17, 0);
      chk("right_1234", {16'd0, last_w[1]}, 32'h1234);

      // Asynchronous reset in the middle of a frame.
      push_at(1, 18, 16'hFFFF);
      push_at(1, 19, 16'h0F0F);
      step_until(0, 7, 2);
      chk("pre_rst_dat", {31'd0, o_aud_dacdat}, 1);
      chk("pre_rst_level", {29'd0, o_level}, 1);
      i_rst_n = 1'b0;
      #1;
      chk("arst_dacdat", {31'd0, o_aud_dacdat}, 0);
      chk("arst_level", {29'd0, o_level}, 0);
      chk("arst_ovf", {31'd0, o_overflow}, 0);
      chk("arst_unf", {31'd0, o_underflow}, 0);
      step_until(0, 12, 2);
      i_rst_n = 1'b1;
      push_at(0, 14, 16'h0BCD);
      step_until(1, 17, 0);
      chk("post_rst_r0", {16'd0, last_w[1]}, 0);
      step_until(0, 17, 0);
      chk("left_0bcd", {16'd0, last_w[0]}, 32'h0BCD);
      step_until(1, 17, 0);
      chk("right_0bcd", {16'd0, last_w[1]}, 32'h0BCD);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
